// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//
// Parametrised LIFO stack with integrated storage.
//
// Behaviour summary:
//   - Push and pop requests are sampled on every rising clock edge.
//   - A pop returns its data one cycle later on pop_data, with a one-cycle
//     pop_valid strobe.
//   - Push and pop in the same cycle:
//       * non-empty stack: the top entry is exchanged (popped value out,
//         pushed value takes its place);
//       * empty stack: the pushed value is bypassed straight to pop_data.
//   - A push on a full stack or a pop on an empty stack is rejected and
//     leaves the stack unchanged.
//
// Optional feature (macro LIFO_STACK_ERR_FLAG_EN):
//   When defined, overflow and underflow are sticky flags, set by rejected
//   push or pop requests and cleared by err_clr. err_clr wins over a set
//   in the same cycle. When the macro is not defined, both outputs are
//   tied to 0 and err_clr is ignored.
//
// Parameters:
//   DEPTH_LOG     log2 of capacity N (N = 2**DEPTH_LOG)
//   WIDTH         data width
//   AFULL_THRESH  almost_full asserts when level >= AFULL_THRESH (1..N)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   push_req     push request
//   push_data    data to push
//   pop_req      pop request
//   err_clr      clear sticky error flags
//   pop_data     registered popped data; holds its value between pops
//   pop_valid    one-cycle strobe: pop_data was updated this cycle
//   level        occupancy, 0..N
//   empty        level == 0
//   full         level == N
//   almost_full  level >= AFULL_THRESH
//   overflow     sticky: a push was rejected because the stack was full
//   underflow    sticky: a pop was rejected because the stack was empty
// -----------------------------------------------------------------------------
module lifo_stack #(
    parameter int DEPTH_LOG    = 4,
    parameter int WIDTH        = 8,
    parameter int AFULL_THRESH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_req,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop_req,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 pop_valid,
    output logic [DEPTH_LOG:0]   level,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                 N           = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_LEVEL  = (DEPTH_LOG+1)'(N);
    localparam logic [DEPTH_LOG:0] AFULL_LEVEL = (DEPTH_LOG+1)'(AFULL_THRESH);

    // Storage: not reset; entries at or above the stack pointer are don't-care.
    logic [WIDTH-1:0]     r_mem [N];

    // Stack pointer: equals the occupancy; the top entry is r_mem[r_sp-1].
    logic [DEPTH_LOG:0]   r_sp;
    logic [WIDTH-1:0]     r_pop_data;
    logic                 r_pop_valid;

    logic                 w_empty;
    logic                 w_full;
    logic [DEPTH_LOG-1:0] w_top_idx;
    logic                 w_do_exch;
    logic                 w_do_bypass;
    logic                 w_do_push;
    logic                 w_do_pop;
    logic                 w_push_rej;
    logic                 w_pop_rej;
    logic                 w_mem_we;
    logic [DEPTH_LOG-1:0] w_mem_waddr;

    // Status flags are decoded directly from the stack pointer.
    // They add no extra latency.
    assign w_empty     = (r_sp == '0);
    assign w_full      = (r_sp == FULL_LEVEL);
    assign w_top_idx   = DEPTH_LOG'(r_sp - 1'b1);

    // Decode the action for this cycle.
    // Each case is mutually exclusive and follows the priority order of the
    // request combinations.
    always_comb begin
        w_do_exch   = 1'b0;
        w_do_bypass = 1'b0;
        w_do_push   = 1'b0;
        w_do_pop    = 1'b0;
        w_push_rej  = 1'b0;
        w_pop_rej   = 1'b0;
        if (push_req && pop_req) begin
            w_do_exch   = !w_empty;
            w_do_bypass = w_empty;
        end else if (push_req) begin
            w_do_push   = !w_full;
            w_push_rej  = w_full;
        end else if (pop_req) begin
            w_do_pop    = !w_empty;
            w_pop_rej   = w_empty;
        end
    end

    // Memory write port.
    //   - Exchange: overwrite the current top entry in place.
    //   - Normal push: write just above the top. w_full is excluded, so
    //     r_sp < N here and the low bits of r_sp form a valid index.
    assign w_mem_we    = w_do_exch || w_do_push;
    assign w_mem_waddr = w_do_exch ? w_top_idx : r_sp[DEPTH_LOG-1:0];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= push_data;
        end
    end

    // Stack pointer and pop output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_do_exch || w_do_bypass || w_do_pop;

            // The exchange path reads the old top in the same cycle that it is
            // overwritten. The non-blocking update keeps the old value visible
            // to this read.
            if (w_do_exch || w_do_pop) begin
                r_pop_data <= r_mem[w_top_idx];
            end else if (w_do_bypass) begin
                r_pop_data <= push_data;
            end

            if (w_do_push) begin
                r_sp <= r_sp + 1'b1;
            end else if (w_do_pop) begin
                r_sp <= r_sp - 1'b1;
            end
        end
    end

    assign pop_data    = r_pop_data;
    assign pop_valid   = r_pop_valid;
    assign level       = r_sp;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_sp >= AFULL_LEVEL);

`ifdef LIFO_STACK_ERR_FLAG_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: err_clr overrides a set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_rej) r_overflow  <= 1'b1;
            if (w_pop_rej)  r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // No flag registers when the feature is disabled.
    // These signals are intentionally left unconsumed.
    logic [2:0] w_unused_err;
    assign w_unused_err = {err_clr, w_push_rej, w_pop_rej};
    assign overflow     = 1'b0;
    assign underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
//
// Self-checking bench for lifo_stack (DEPTH_LOG=4, WIDTH=8, AFULL_THRESH=14).
// The reference model is a queue of pushed values plus the expected pop
// outputs and sticky flags, updated from the stack's rules each cycle.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    localparam int N     = 16;
    localparam int AFULL = 14;
`ifdef LIFO_STACK_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_req = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop_req = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] q[$];
    logic [7:0] exp_pop_data;
    logic       exp_pop_valid;
    logic       exp_ovf;
    logic       exp_unf;

    lifo_stack #(.DEPTH_LOG(4), .WIDTH(8), .AFULL_THRESH(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_req   (push_req),
        .push_data  (push_data),
        .pop_req    (pop_req),
        .err_clr    (err_clr),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Apply one sampled request to the reference model.
    task automatic model_step(input logic p, input logic o, input logic [7:0] d, input logic c);
        logic set_ovf = 1'b0;
        logic set_unf = 1'b0;
        exp_pop_valid = 1'b0;
        if (p && o) begin
            if (q.size() > 0) begin
                exp_pop_data = q[q.size()-1];
                q[q.size()-1] = d;
            end else begin
                exp_pop_data = d;
            end
            exp_pop_valid = 1'b1;
        end else if (p) begin
            if (q.size() < N) q.push_back(d);
            else set_ovf = 1'b1;
        end else if (o) begin
            if (q.size() > 0) begin
                exp_pop_data  = q.pop_back();
                exp_pop_valid = 1'b1;
            end else begin
                set_unf = 1'b1;
            end
        end
        if (!ERR_EN || c) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = exp_ovf | set_ovf;
            exp_unf = exp_unf | set_unf;
        end
    endtask

    // Drive one request across one rising edge.
    // Returns 1 ns after the edge, with the request deasserted.
    task automatic cycle(input logic p, input logic o, input logic [7:0] d, input logic c);
        push_req  = p;
        pop_req   = o;
        push_data = d;
        err_clr   = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #1;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_clr  = 1'b0;
        $display("txn t=%0t push=%0b pop=%0b clr=%0b data=%02h -> level=%0d pop_valid=%0b pop_data=%02h ovf=%0b unf=%0b",
                 $time, p, o, c, d, level, pop_valid, pop_data, overflow, underflow);
    endtask

    // Reset the DUT and the model.
    // Release the reset away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        push_req = 1'b0;
        pop_req = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        exp_pop_data = 8'h00;
        exp_pop_valid = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({level, empty, full, almost_full, pop_valid, pop_data, overflow, underflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got level=%0d empty=%0b full=%0b afull=%0b pv=%0b pd=%02h ovf=%0b unf=%0b, want 0 1 0 0 0 00 0 0",
                     level, empty, full, almost_full, pop_valid, pop_data, overflow, underflow);
        end
    endtask

    task automatic test_order();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, vals[i], 1'b0);
            checks++;
            if (level !== 5'(i + 1)) begin
                failures++;
                $display("FAIL order_push_level: got %0d want %0d", level, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== vals[2-i] || level !== 5'(2 - i)) begin
                failures++;
                $display("FAIL order_pop: got pv=%0b pd=%02h level=%0d want pv=1 pd=%02h level=%0d",
                         pop_valid, pop_data, level, vals[2-i], 2 - i);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL order_empty: got %0b want 1", empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= N; i++) begin
            cycle(1'b1, 1'b0, 8'(i * 3), 1'b0);
            checks++;
            if (level !== 5'(i) || full !== (i == N) || almost_full !== (i >= AFULL)) begin
                failures++;
                $display("FAIL fill_flags: got level=%0d full=%0b afull=%0b want level=%0d full=%0b afull=%0b",
                         level, full, almost_full, i, (i == N), (i >= AFULL));
            end
        end
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        checks++;
        if (level !== 5'd16 || full !== 1'b1 || overflow !== ERR_EN) begin
            failures++;
            $display("FAIL fill_overflow: got level=%0d full=%0b ovf=%0b want level=16 full=1 ovf=%0b",
                     level, full, overflow, ERR_EN);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (pop_data !== 8'(N * 3) || pop_valid !== 1'b1 || overflow !== ERR_EN) begin
            failures++;
            $display("FAIL fill_top_after_reject: got pd=%02h pv=%0b ovf=%0b want pd=%02h pv=1 ovf=%0b",
                     pop_data, pop_valid, overflow, 8'(N * 3), ERR_EN);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b1, 1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (pop_valid !== 1'b0 || pop_data !== 8'h3C || underflow !== ERR_EN || level !== 5'd0) begin
            failures++;
            $display("FAIL underflow_set: got pv=%0b pd=%02h unf=%0b level=%0d want pv=0 pd=3c unf=%0b level=0",
                     pop_valid, pop_data, underflow, level, ERR_EN);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (underflow !== ERR_EN) begin
            failures++;
            $display("FAIL underflow_sticky: got %0b want %0b", underflow, ERR_EN);
        end
        // err_clr wins over a same-cycle rejected pop.
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clr: got %0b want 0", underflow);
        end
    endtask

    task automatic test_exchange();
        do_reset();
        cycle(1'b1, 1'b0, 8'h0F, 1'b0);
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        checks++;
        if (pop_data !== 8'hA5 || pop_valid !== 1'b1 || level !== 5'd2) begin
            failures++;
            $display("FAIL exchange: got pd=%02h pv=%0b level=%0d want a5 1 2", pop_data, pop_valid, level);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (pop_data !== 8'h5A || pop_valid !== 1'b1 || level !== 5'd1) begin
            failures++;
            $display("FAIL exchange_followup: got pd=%02h pv=%0b level=%0d want 5a 1 1", pop_data, pop_valid, level);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        checks++;
        if (pop_data !== 8'h77 || pop_valid !== 1'b1 || level !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL bypass: got pd=%02h pv=%0b level=%0d ovf=%0b unf=%0b want 77 1 0 0 0",
                     pop_data, pop_valid, level, overflow, underflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        // The stack now holds 5 entries and pop_valid is high.
        // Assert reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 5'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || pop_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: got level=%0d empty=%0b pv=%0b pd=%02h want 0 1 0 00",
                     level, empty, pop_valid, pop_data);
        end
        do_reset();
    endtask

    task automatic test_random();
        int pw;
        for (int i = 0; i < 600; i++) begin
            // Bias the push rate in phases so that both full and empty are
            // reached repeatedly.
            pw = ((i / 60) % 2 == 0) ? 80 : 25;
            cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < 45),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
            checks++;
            if (level !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == N) ||
                almost_full !== (q.size() >= AFULL) || pop_valid !== exp_pop_valid ||
                pop_data !== exp_pop_data || overflow !== exp_ovf || underflow !== exp_unf) begin
                failures++;
                $display("FAIL random_step%0d: got level=%0d e=%0b f=%0b af=%0b pv=%0b pd=%02h ovf=%0b unf=%0b want level=%0d pv=%0b pd=%02h ovf=%0b unf=%0b",
                         i, level, empty, full, almost_full, pop_valid, pop_data, overflow, underflow,
                         q.size(), exp_pop_valid, exp_pop_data, exp_ovf, exp_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_underflow();
        test_exchange();
        test_bypass();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Self-contained, parametrised LIFO stack for the memory library: it owns its storage array and exposes push/pop request ports with registered pop data and a valid strobe. It extends the earlier stack controller with integrated storage, read-back of popped data, simultaneous push+pop (top exchange), empty bypass, an occupancy count, a programmable almost-full flag and optional sticky error flags. Used wherever a block needs a bounded hardware call/return or undo stack.

## Interface
- DEPTH_LOG, 4: log2 of entry count; capacity N = 2**DEPTH_LOG.
- WIDTH, 8: data width in bits.
- AFULL_THRESH, 14: almost_full asserts when level >= AFULL_THRESH; legal range 1..N.

- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- push_req  input  1  push request, sampled each cycle.
- push_data  input  WIDTH  data to push.
- pop_req  input  1  pop request, sampled each cycle.
- err_clr  input  1  clears sticky error flags (only with LIFO_STACK_ERR_FLAG_EN).
- pop_data  output  WIDTH  registered popped data, holds value between pops.
- pop_valid  output  1  one-cycle strobe, pop_data updated this cycle.
- level  output  DEPTH_LOG+1  current occupancy 0..N.
- empty  output  1  level == 0.
- full  output  1  level == N.
- almost_full  output  1  level >= AFULL_THRESH.
- overflow  output  1  sticky: push rejected because full.
- underflow  output  1  sticky: pop rejected because empty.

## Operation
- Storage: N x WIDTH register array mem; stack pointer sp (DEPTH_LOG+1 bits) equals level; top entry is mem[sp-1].
- empty/full/almost_full: combinational decode of sp only, no extra latency.
- Per-cycle action, evaluated in priority order:
  - push_req && pop_req && !empty: exchange; pop_data <= mem[sp-1], mem[sp-1] <= push_data, pop_valid <= 1, sp unchanged. Legal when full.
  - push_req && pop_req && empty: bypass; pop_data <= push_data, pop_valid <= 1, mem and sp unchanged.
  - push_req && !full: mem[sp] <= push_data, sp <= sp+1.
  - push_req && full: rejected, no state change; overflow set.
  - pop_req && !empty: pop_data <= mem[sp-1], pop_valid <= 1, sp <= sp-1.
  - pop_req && empty: rejected, pop_valid stays 0, pop_data holds; underflow set.
  - idle: pop_valid <= 0, everything else holds.
- sp never wraps: saturates at 0 and N by rejection, not arithmetic.
- Popped entries are not cleared; mem contents above sp are don't-care.

## Timing
- Reset values: sp = 0, pop_data = 0, pop_valid = 0, overflow = 0, underflow = 0; hence level = 0, empty = 1, full = 0, almost_full = 0. mem contents not reset.
- Reset mid-operation discards all entries immediately (asynchronous); first request is sampled on the first rising edge after rst_n deasserts.
- Push: level/flags reflect the new entry in the cycle after the request edge.
- Pop: latency 1; pop_data and pop_valid valid in the cycle after the request edge, level decremented in the same cycle.
- Back-to-back push then pop returns the just-pushed data; back-to-back pops at full rate return successively older entries.
- No backpressure on pop_data; consumer must capture on pop_valid.

## Configuration
- LIFO_STACK_ERR_FLAG_EN defined: overflow/underflow set on the rejection cases above and hold until err_clr is sampled high; err_clr has priority over a same-cycle set. Exchange and bypass never set either flag.
- Not defined: overflow and underflow tied to 0, err_clr ignored, no flag registers synthesised.

## Test plan
- Reset, then push 0x11,0x22,0x33, then three pops -> pop_data 0x33,0x22,0x11 on consecutive pop_valid strobes; level 3->0; empty back to 1.
- Push 16 values (DEPTH_LOG=4) -> full=1 at level 16, almost_full=1 from level 14; 17th push -> level stays 16, overflow=1 (with macro).
- Pop on empty -> pop_valid stays 0, pop_data unchanged, underflow=1; err_clr pulse -> underflow=0.
- Level 2 (top 0xA5), push 0x5A with pop same cycle -> next cycle pop_data=0xA5, pop_valid=1, level 2; following pop returns 0x5A.
- Empty, push 0x77 with pop same cycle -> pop_data=0x77, pop_valid=1, level 0, no error flag.
- Level 5, assert rst_n low mid-cycle -> level 0, empty=1, pop_valid=0 immediately without a clock edge.
